// File: rtl/rx_desc_queue.sv
`default_nettype none
// ============================================================================
//  Module   : rx_desc_queue
//  Purpose  : Descriptor FIFO feeding the BRAM->AXIS RX packet reader.
//             Validates pushed (address, length) descriptors, queues the
//             legal ones, presents the head on the reader handshake and
//             issues a completion for every popped buffer.
//  Ports    : axi_clk/axi_aresetn   clock, async active-low reset
//             desc_*_i / desc_rdy_o  descriptor push side (valid/ready)
//             desc_drop_o            pulse: accepted descriptor was illegal
//             pkt_*_o / pkt_ack_i    head presentation and reader ack
//             cmpl_*_o               completion pulse with freed address
//             fill_o, pkt_cnt_o, drop_cnt_o, err_ack_o   status
//  Revision : 1.0  initial release
// ============================================================================
module rx_desc_queue #(
    parameter int DEPTH    = 16,
    parameter int MAX_LEN  = 1518,
    parameter int MEM_SIZE = 131072
) (
    input  logic                       axi_clk,
    input  logic                       axi_aresetn,
    input  logic [31:0]                desc_addr_i,
    input  logic [15:0]                desc_len_i,
    input  logic                       desc_v_i,
    output logic                       desc_rdy_o,
    output logic                       desc_drop_o,
    output logic [31:0]                pkt_addr_o,
    output logic [15:0]                pkt_len_o,
    output logic                       pkt_addr_v_o,
    input  logic                       pkt_ack_i,
    output logic [31:0]                cmpl_addr_o,
    output logic                       cmpl_v_o,
    output logic [$clog2(DEPTH):0]     fill_o,
    output logic [31:0]                pkt_cnt_o,
    output logic [31:0]                drop_cnt_o,
    output logic                       err_ack_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    // Storage is never reset: entries are only read while counted by fill.
    logic [31:0]   addr_mem_q [DEPTH];
    logic [15:0]   len_mem_q  [DEPTH];

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FW-1:0] fill_q, fill_d;
    logic          live_q;      // low in reset, high from the first edge after release
    logic          ack_q;
    logic          drop_q;
    logic          cmpl_v_q;
    logic [31:0]   cmpl_addr_q;
    logic [31:0]   pkt_cnt_q, drop_cnt_q;
    logic          err_ack_q;

    logic          w_accept, w_bad, w_push, w_ack_rise, w_pop, w_head_v;
    logic [32:0]   w_end;

    // End address computed on 33 bits so a huge address cannot wrap to a legal one.
    assign w_end      = {1'b0, desc_addr_i} + {17'd0, desc_len_i};
    assign w_bad      = (desc_len_i == 16'd0) ||
                        (desc_len_i > 16'(MAX_LEN)) ||
                        (w_end > 33'(MEM_SIZE));
    assign w_accept   = desc_v_i && desc_rdy_o;
    assign w_push     = w_accept && !w_bad;
    assign w_head_v   = (fill_q != FW'(0));
    // Only the rising edge of ack pops, so a held ack retires one entry.
    assign w_ack_rise = pkt_ack_i && !ack_q;
    assign w_pop      = w_ack_rise && w_head_v;

    always_comb begin
        fill_d = fill_q;
        case ({w_push, w_pop})
            2'b10:   fill_d = fill_q + FW'(1);
            2'b01:   fill_d = fill_q - FW'(1);
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (w_push) begin
            addr_mem_q[wr_ptr_q] <= desc_addr_i;
            len_mem_q[wr_ptr_q]  <= desc_len_i;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            live_q      <= 1'b0;
            ack_q       <= 1'b0;
            drop_q      <= 1'b0;
            cmpl_v_q    <= 1'b0;
            cmpl_addr_q <= '0;
            pkt_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            err_ack_q   <= 1'b0;
        end else begin
            live_q   <= 1'b1;
            ack_q    <= pkt_ack_i;
            fill_q   <= fill_d;
            drop_q   <= w_accept && w_bad;
            cmpl_v_q <= w_pop;
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_accept && w_bad) begin
                drop_cnt_q <= drop_cnt_q + 32'd1;
            end
            if (w_pop) begin
                rd_ptr_q    <= rd_ptr_q + AW'(1);
                pkt_cnt_q   <= pkt_cnt_q + 32'd1;
                cmpl_addr_q <= addr_mem_q[rd_ptr_q];
            end
            if (w_ack_rise && !w_head_v) begin
                err_ack_q <= 1'b1;
            end
        end
    end

    assign desc_rdy_o   = live_q && (fill_q != FW'(DEPTH));
    assign desc_drop_o  = drop_q;
    // Head fields are forced to zero when empty so stale storage never leaks out.
    assign pkt_addr_v_o = w_head_v;
    assign pkt_addr_o   = w_head_v ? addr_mem_q[rd_ptr_q] : 32'd0;
    assign pkt_len_o    = w_head_v ? len_mem_q[rd_ptr_q]  : 16'd0;
    assign cmpl_v_o     = cmpl_v_q;
    assign cmpl_addr_o  = cmpl_addr_q;
    assign fill_o       = fill_q;
    assign pkt_cnt_o    = pkt_cnt_q;
    assign drop_cnt_o   = drop_cnt_q;
    assign err_ack_o    = err_ack_q;

endmodule
`default_nettype wire
